// File: rtl/parking_pkg.sv
// Shared constants and FSM encoding for the parking slot manager.
package parking_pkg;

    localparam int NSLOT   = 8;
    localparam int SLOT_W  = 3;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DENY  = 2'd2
    } state_t;

endpackage

// File: rtl/slot_pick.sv
// Combinational lowest-index free-slot finder over a busy bitmap.
module slot_pick #(
    parameter int NSLOT  = parking_pkg::NSLOT,
    parameter int SLOT_W = parking_pkg::SLOT_W
) (
    input  logic [NSLOT-1:0]  busy,
    output logic [SLOT_W-1:0] idx,
    output logic              any_free
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx      = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_slot_manager.sv
// Gate-side slot allocator: grants the lowest free slot on each new car arrival,
// reserves it until park confirmation or timeout, and tracks occupancy on exits.
module parking_slot_manager #(
    parameter int NSLOT   = parking_pkg::NSLOT,
    parameter int TIMEOUT = parking_pkg::TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sn,
    input  logic                           park_ok,
    input  logic                           exit_vld,
    input  logic [parking_pkg::SLOT_W-1:0] exit_slot,
    output logic                           gL,
    output logic                           rL,
    output logic [parking_pkg::SLOT_W-1:0] slot_id,
    output logic [parking_pkg::CNT_W-1:0]  free_cnt,
    output logic [NSLOT-1:0]               occ,
    output logic [1:0]                     dbg_state
);

    import parking_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    // park_ok and exit_vld are valid-only pulses with no ready: each one is
    // consumed at the edge it is sampled, either applied or silently dropped.
    state_t             state_q, state_d;
    logic               sn_q;
    logic               gl_q, gl_d, rl_q, rl_d;
    logic [SLOT_W-1:0]  slot_id_q, slot_id_d;
    logic [NSLOT-1:0]   occ_q, occ_d, rsv_q, rsv_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   free_cnt_q, free_cnt_d, used;
    logic [NSLOT-1:0]   busy;
    logic [SLOT_W-1:0]  pick_idx;
    logic               any_free, req, exit_hit;

    assign busy = occ_q | rsv_q;
    assign req  = sn & ~sn_q;

    slot_pick #(.NSLOT(NSLOT), .SLOT_W(SLOT_W)) u_pick (
        .busy     (busy),
        .idx      (pick_idx),
        .any_free (any_free)
    );

    always_comb begin
        exit_hit = 1'b0;
        if (exit_vld && int'(exit_slot) < NSLOT)
            exit_hit = occ_q[exit_slot] && !rsv_q[exit_slot];
    end

    always_comb begin
        state_d   = state_q;
        gl_d      = gl_q;
        rl_d      = rl_q;
        slot_id_d = slot_id_q;
        occ_d     = occ_q;
        rsv_d     = rsv_q;
        timer_d   = timer_q;
        if (exit_hit)
            occ_d[exit_slot] = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (any_free) begin
                        state_d            = GRANT;
                        gl_d               = 1'b1;
                        slot_id_d          = pick_idx;
                        rsv_d[pick_idx]    = 1'b1;
                        timer_d            = '0;
                    end else begin
                        state_d = DENY;
                        rl_d    = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (park_ok) begin
                    occ_d[slot_id_q] = 1'b1;
                    rsv_d[slot_id_q] = 1'b0;
                    gl_d             = 1'b0;
                    timer_d          = '0;
                    state_d          = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsv_d[slot_id_q] = 1'b0;
                    gl_d             = 1'b0;
                    timer_d          = '0;
                    state_d          = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DENY: begin
                if (!sn) begin
                    rl_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free count is taken from the post-edge occupancy and reservations.
    always_comb begin
        used = '0;
        for (int i = 0; i < NSLOT; i++)
            used = used + CNT_W'(occ_d[i]) + CNT_W'(rsv_d[i]);
        free_cnt_d = CNT_W'(NSLOT) - used;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sn_q       <= 1'b0;
            gl_q       <= 1'b0;
            rl_q       <= 1'b0;
            slot_id_q  <= '0;
            occ_q      <= '0;
            rsv_q      <= '0;
            timer_q    <= '0;
            free_cnt_q <= CNT_W'(NSLOT);
        end else begin
            state_q    <= state_d;
            sn_q       <= sn;
            gl_q       <= gl_d;
            rl_q       <= rl_d;
            slot_id_q  <= slot_id_d;
            occ_q      <= occ_d;
            rsv_q      <= rsv_d;
            timer_q    <= timer_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign gL        = gl_q;
    assign rL        = rl_q;
    assign slot_id   = slot_id_q;
    assign free_cnt  = free_cnt_q;
    assign occ       = occ_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed vector bench for parking_slot_manager: one table row per clock cycle.
module tb_parking_slot_manager;

    logic       clk = 1'b0;
    logic       rst, sn, park_ok, exit_vld;
    logic [2:0] exit_slot;
    logic       gL, rL;
    logic [2:0] slot_id;
    logic [3:0] free_cnt;
    logic [7:0] occ;
    logic [1:0] dbg_state;

    int tests  = 0;
    int failed = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_DENY = 2'd2;

    parking_slot_manager #(.NSLOT(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sn        (sn),
        .park_ok   (park_ok),
        .exit_vld  (exit_vld),
        .exit_slot (exit_slot),
        .gL        (gL),
        .rL        (rL),
        .slot_id   (slot_id),
        .free_cnt  (free_cnt),
        .occ       (occ),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst, sn, pk, ev;
        logic [2:0] es;
        logic       gl, rl;
        logic [2:0] sid;
        logic [3:0] free;
        logic [7:0] occ;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic r, logic s, logic pk, logic ev,
                                logic [2:0] es, logic gl, logic rl, logic [2:0] sid,
                                logic [3:0] free, logic [7:0] o, logic [1:0] st);
        vec_t v;
        v.name = name; v.rst = r; v.sn = s; v.pk = pk; v.ev = ev; v.es = es;
        v.gl = gl; v.rl = rl; v.sid = sid; v.free = free; v.occ = o; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst; sn = v.sn; park_ok = v.pk; exit_vld = v.ev; exit_slot = v.es;
        @(posedge clk);
        #1;
        tests++;
        if (gL !== v.gl || rL !== v.rl || slot_id !== v.sid || free_cnt !== v.free ||
            occ !== v.occ || dbg_state !== v.st || (gL === 1'b1 && rL === 1'b1)) begin
            failed++;
            $display("FAIL %s: got gL=%b rL=%b slot_id=%0d free_cnt=%0d occ=%h state=%0d, expected gL=%b rL=%b slot_id=%0d free_cnt=%0d occ=%h state=%0d",
                     v.name, gL, rL, slot_id, free_cnt, occ, dbg_state,
                     v.gl, v.rl, v.sid, v.free, v.occ, v.st);
        end
    endtask

    initial begin
        logic [7:0] o;
        rst = 1'b0; sn = 1'b0; park_ok = 1'b0; exit_vld = 1'b0; exit_slot = 3'd0;

        // Reset with busy inputs: all must be ignored.
        add("reset0", 0, 1, 1, 1, 3'd0, 0, 0, 3'd0, 4'd8, 8'h00, S_IDLE);
        add("reset1", 0, 0, 1, 1, 3'd5, 0, 0, 3'd0, 4'd8, 8'h00, S_IDLE);
        // First grant and park.
        add("grant0", 1, 1, 0, 0, 3'd0, 1, 0, 3'd0, 4'd7, 8'h00, S_GRANT);
        add("park0",  1, 1, 1, 0, 3'd0, 0, 0, 3'd0, 4'd7, 8'h01, S_IDLE);
        add("exit_unocc", 1, 0, 0, 1, 3'd2, 0, 0, 3'd0, 4'd7, 8'h01, S_IDLE);
        add("park_idle",  1, 0, 1, 0, 3'd0, 0, 0, 3'd0, 4'd7, 8'h01, S_IDLE);
        // Fill slots 1..7.
        for (int s = 1; s < 8; s++) begin
            o = 8'((1 << s) - 1);
            add($sformatf("grant%0d", s), 1, 1, 0, 0, 3'd0, 1, 0, 3'(s), 4'(7 - s), o, S_GRANT);
            o = 8'((1 << (s + 1)) - 1);
            add($sformatf("park%0d", s), 1, 0, 1, 0, 3'd0, 0, 0, 3'(s), 4'(7 - s), o, S_IDLE);
        end
        // Full: deny, hold, release.
        add("deny",      1, 1, 0, 0, 3'd0, 0, 1, 3'd7, 4'd0, 8'hFF, S_DENY);
        add("deny_hold", 1, 1, 0, 0, 3'd0, 0, 1, 3'd7, 4'd0, 8'hFF, S_DENY);
        add("deny_rel",  1, 0, 0, 0, 3'd0, 0, 0, 3'd7, 4'd0, 8'hFF, S_IDLE);
        // Exit at the same edge as a request: allocation sees the pre-edge full map.
        add("deny_exit4",   1, 1, 0, 1, 3'd4, 0, 1, 3'd7, 4'd1, 8'hEF, S_DENY);
        add("deny_no_regr", 1, 1, 0, 0, 3'd0, 0, 1, 3'd7, 4'd1, 8'hEF, S_DENY);
        add("deny_rel2",    1, 0, 0, 0, 3'd0, 0, 0, 3'd7, 4'd1, 8'hEF, S_IDLE);
        add("grant4",       1, 1, 0, 0, 3'd0, 1, 0, 3'd4, 4'd0, 8'hEF, S_GRANT);
        add("exit_rsv",     1, 0, 0, 1, 3'd4, 1, 0, 3'd4, 4'd0, 8'hEF, S_GRANT);
        add("park_exit_same", 1, 0, 1, 1, 3'd4, 0, 0, 3'd4, 4'd0, 8'hFF, S_IDLE);
        add("exit0",        1, 0, 0, 1, 3'd0, 0, 0, 3'd4, 4'd1, 8'hFE, S_IDLE);
        add("grant_exit7",  1, 1, 0, 1, 3'd7, 1, 0, 3'd0, 4'd1, 8'h7E, S_GRANT);
        add("park_s0",      1, 1, 1, 0, 3'd0, 0, 0, 3'd0, 4'd1, 8'h7F, S_IDLE);

        // Timeout sequence from occ=07.
        add("reset2", 0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'd8, 8'h00, S_IDLE);
        for (int s = 0; s < 3; s++) begin
            add($sformatf("tgrant%0d", s), 1, 1, 0, 0, 3'd0, 1, 0, 3'(s), 4'(7 - s), 8'((1 << s) - 1), S_GRANT);
            add($sformatf("tpark%0d", s),  1, 0, 1, 0, 3'd0, 0, 0, 3'(s), 4'(7 - s), 8'((1 << (s + 1)) - 1), S_IDLE);
        end
        add("tgrant3", 1, 1, 0, 0, 3'd0, 1, 0, 3'd3, 4'd4, 8'h07, S_GRANT);
        for (int c = 1; c <= 15; c++)
            add($sformatf("twait%0d", c), 1, 0, 0, 0, 3'd0, 1, 0, 3'd3, 4'd4, 8'h07, S_GRANT);
        add("timeout",      1, 0, 0, 0, 3'd0, 0, 0, 3'd3, 4'd5, 8'h07, S_IDLE);
        add("late_park",    1, 0, 1, 0, 3'd0, 0, 0, 3'd3, 4'd5, 8'h07, S_IDLE);

        // Reset in the middle of a grant, park_ok must not land.
        add("rgrant3",      1, 1, 0, 0, 3'd0, 1, 0, 3'd3, 4'd4, 8'h07, S_GRANT);
        add("reset_grant",  0, 0, 1, 0, 3'd0, 0, 0, 3'd0, 4'd8, 8'h00, S_IDLE);
        add("post_reset",   1, 1, 0, 0, 3'd0, 1, 0, 3'd0, 4'd7, 8'h00, S_GRANT);

        foreach (vecs[i]) apply(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/parking_slot_manager.md
PARKING_SLOT_MANAGER -- requirements
Module: parking_slot_manager

Interface
REQ-001 Parameter NSLOT, default 8, number of parking slots.
REQ-002 Parameter TIMEOUT, default 16, clock cycles allowed between grant and park confirmation.
REQ-003 clk  in  1  single system clock, rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 sn  in  1  entry sensor, level, high while a car waits at the gate.
REQ-006 park_ok  in  1  one-cycle pulse, car confirmed in the granted slot.
REQ-007 exit_vld  in  1  one-cycle pulse, a car has left slot exit_slot.
REQ-008 exit_slot  in  3  index of the vacated slot, valid only with exit_vld.
REQ-009 gL  out  1  slot granted, feeds the gate controller's location-available input.
REQ-010 rL  out  1  car park full, feeds the gate controller's no-location input.
REQ-011 slot_id  out  3  granted slot index, valid while gL=1.
REQ-012 free_cnt  out  4  slots neither occupied nor reserved.
REQ-013 occ  out  NSLOT  occupancy bitmap, bit i=1 means slot i is occupied.

Function
REQ-014 All outputs shall be registered.
REQ-015 FSM states shall be IDLE, GRANT and DENY.
REQ-016 A request shall be a rising edge of sn: sn=1 in the current cycle and sn=0 in the previous cycle.
- A level held high shall not re-request.
REQ-017 IDLE, request seen at edge k, a free slot exists: at edge k+1 go to GRANT.
- gL=1, slot_id = lowest index i with occ[i]=0 and not reserved.
- Reserve slot i.
REQ-018 IDLE, request seen at edge k, no free slot: at edge k+1 go to DENY with rL=1.
REQ-019 GRANT, park_ok=1: set occ[slot_id], clear the reservation, gL=0, go to IDLE.
REQ-020 GRANT, TIMEOUT cycles elapse without park_ok: release the reservation, gL=0, go to IDLE, occ unchanged.
REQ-021 DENY: rL stays 1 while sn=1.
- First cycle with sn=0: rL=0, go to IDLE.
- A slot freed during DENY shall not grant until a new sn rising edge.
REQ-022 exit_vld with occ[exit_slot]=1 shall clear that bit at the same edge.
REQ-023 exit_vld shall be ignored, with no state change, when the slot is unoccupied, reserved, or exit_slot >= NSLOT.
REQ-024 park_ok outside GRANT shall be ignored.
REQ-025 Allocation shall use the pre-edge occupancy.
- A slot freed by exit_vld at the same edge is not grantable until the next cycle.
REQ-026 park_ok and exit_vld on the same slot in the same cycle: the slot ends occupied (exit ignored per REQ-023).
REQ-027 free_cnt shall equal NSLOT − popcount(occ) − reserved count, reflecting the post-edge state.
REQ-028 gL and rL shall never both be 1.
REQ-029 slot_id shall hold its value until the next grant.

Reset
REQ-030 While rst=0 at a rising edge, the block shall load: state IDLE, occ=0, no reservation, gL=0, rL=0, slot_id=0, free_cnt=NSLOT, timer=0, sn history=0.
- All inputs shall be ignored during reset.
REQ-031 Reset asserted mid-GRANT or mid-DENY shall abort the transaction, with no partial occupancy update.

Structure
REQ-032 Package parking_pkg shall hold NSLOT, SLOT_W=3, TIMEOUT and the FSM state enum.
REQ-033 Sub-module slot_pick shall be combinational.
- Input: NSLOT-bit busy vector (occ OR reservation).
- Outputs: lowest free index and an any_free flag.
REQ-034 The timeout counter shall be wide enough to count to TIMEOUT.

Verification
REQ-035 Reset, then sn 0→1 → next cycle gL=1, slot_id=0, free_cnt=7; park_ok pulse → gL=0, occ=8'h01, free_cnt=7.
REQ-036 Fill all 8 slots, then sn rising → rL=1 one cycle later, gL=0; rL holds while sn=1; sn=0 → rL=0 next edge.
REQ-037 occ=8'h07, grant (slot_id=3), no park_ok → after 16 cycles gL=0, occ=8'h07, free_cnt=5.
REQ-038 occ=8'hFF, exit_vld with exit_slot=4 in the same cycle as sn rising → rL=1 (pre-edge full), occ=8'hEF; next sn rising edge → slot_id=4.
REQ-039 exit_vld with exit_slot=2 while occ=8'h01 → occ unchanged, free_cnt unchanged.
REQ-040 rst=0 asserted during GRANT → next edge gL=0, occ=0, free_cnt=8, state IDLE.
